mig_burst_arbiter: RTL and testbench

- Two-requester burst arbiter in front of the DDR3 MIG user (app_*) interface; runs in the MIG ui_clk domain.
- Write port serves the HDMI capture frame writer; read port serves the scanout frame reader.
- Grants whole bursts round-robin and sequences app_cmd/app_en/app_wdf_* per beat.
- Holds off all traffic until init_calib_complete.

---
 rtl/mig_burst_arbiter.sv | 156 +++++++++++++++
 tb/tb_mig_burst_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_burst_arbiter.sv
// Round-robin burst arbiter between a frame writer and a frame reader in front of
// the DDR3 MIG app_* interface. One MIG command per beat; runs in the ui_clk domain.
module mig_burst_arbiter #(
    parameter int ADDR_W   = 29,
    parameter int DATA_W   = 128,
    parameter int LEN_W    = 8,
    parameter int ADDR_INC = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  init_calib_complete,
    output logic [ADDR_W-1:0]     app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    input  logic                  app_rdy,
    output logic [DATA_W-1:0]     app_wdf_data,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    output logic [DATA_W/8-1:0]   app_wdf_mask,
    input  logic                  app_wdf_rdy,
    input  logic [DATA_W-1:0]     app_rd_data,
    input  logic                  app_rd_data_valid,
    output logic                  app_ref_req,
    output logic                  app_zq_req,
    input  logic                  wr_req,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [LEN_W-1:0]      wr_len,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_data_valid,
    output logic                  wr_data_ready,
    output logic                  wr_done,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_addr,
    input  logic [LEN_W-1:0]      rd_len,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_data_valid,
    output logic                  rd_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(ADDR_INC);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                last_rd_q, last_rd_d;
    logic                wr_done_q, wr_done_d;
    logic                rd_done_q, rd_done_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                beat;
    logic                grant_wr;
    logic                grant_rd;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        last_rd_d     = last_rd_q;
        wr_done_d     = 1'b0;
        rd_done_d     = 1'b0;
        app_en        = 1'b0;
        app_cmd       = 3'b000;
        app_wdf_wren  = 1'b0;
        wr_data_ready = 1'b0;
        beat          = 1'b0;
        grant_wr      = 1'b0;
        grant_rd      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (init_calib_complete) begin
                    // On a tie the requester that did not go last wins
                    grant_wr = wr_req && (!rd_req || last_rd_q);
                    grant_rd = rd_req && !grant_wr;
                end
                if (grant_wr) begin
                    addr_d    = wr_addr;
                    cnt_d     = wr_len;
                    last_rd_d = 1'b0;
                    if (wr_len == '0) wr_done_d = 1'b1;
                    else              state_d   = S_WR;
                end else if (grant_rd) begin
                    addr_d    = rd_addr;
                    cnt_d     = rd_len;
                    last_rd_d = 1'b1;
                    if (rd_len == '0) rd_done_d = 1'b1;
                    else              state_d   = S_RD;
                end
            end
            S_WR: begin
                wr_data_ready = app_rdy & app_wdf_rdy;
                if (wr_data_valid && wr_data_ready) begin
                    app_en       = 1'b1;
                    app_wdf_wren = 1'b1;
                    beat         = 1'b1;
                end
            end
            S_RD: begin
                app_en  = 1'b1;
                app_cmd = 3'b001;
                beat    = app_rdy;
            end
            default: state_d = S_IDLE;
        endcase

        if (beat) begin
            addr_d = addr_q + INC;
            cnt_d  = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
                state_d   = S_IDLE;
                wr_done_d = (state_q == S_WR);
                rd_done_d = (state_q == S_RD);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            last_rd_q  <= 1'b1;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            last_rd_q  <= last_rd_d;
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
            rd_data_q  <= app_rd_data;
            rd_valid_q <= app_rd_data_valid;
        end
    end

    assign app_addr      = addr_q;
    assign app_wdf_data  = app_wdf_wren ? wr_data : '0;
    assign app_wdf_end   = app_wdf_wren;
    assign app_wdf_mask  = '0;
    assign app_ref_req   = 1'b0;
    assign app_zq_req    = 1'b0;
    assign wr_done       = wr_done_q;
    assign rd_done       = rd_done_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;

endmodule

// File: tb/tb_mig_burst_arbiter.sv
// Scoreboard bench for mig_burst_arbiter: expected MIG commands are queued as bursts
// are requested and compared against commands the MIG side accepts.
module tb_mig_burst_arbiter;

  localparam int AW = 29;
  localparam int DW = 128;
  localparam int LW = 8;
  localparam int CW = 3 + AW + DW + 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          init_calib_complete = 1'b0;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy = 1'b1;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [DW/8-1:0] app_wdf_mask;
  logic          app_wdf_rdy = 1'b1;
  logic [DW-1:0] app_rd_data = '0;
  logic          app_rd_data_valid = 1'b0;
  logic          app_ref_req;
  logic          app_zq_req;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [LW-1:0] wr_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_data_valid = 1'b0;
  logic          wr_data_ready;
  logic          wr_done;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [LW-1:0] rd_len = '0;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          rd_done;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int proto_err = 0;
  logic bp_mode = 1'b0;

  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] obs_q[$];
  int unsigned   obs_cyc[$];
  logic [DW-1:0] src_q[$];
  int unsigned   wr_done_cyc[$];
  int unsigned   rd_done_cyc[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [DW-1:0] rd_obs_q[$];
  int unsigned   rd_obs_cyc[$];

  mig_burst_arbiter dut (
    .clk(clk), .resetn(resetn), .init_calib_complete(init_calib_complete),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_ref_req(app_ref_req), .app_zq_req(app_zq_req),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .rd_done(rd_done)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // monitor: records accepted commands, done pulses and read returns
  always @(negedge clk) begin
    if (resetn) begin
      if (app_en && app_rdy) begin
        obs_q.push_back({app_cmd, app_addr, (app_wdf_wren ? app_wdf_data : {DW{1'b0}}), app_wdf_wren, app_wdf_end});
        obs_cyc.push_back(cyc);
        if (app_wdf_wren && src_q.size() > 0) void'(src_q.pop_front());
      end
      if (!app_rdy && (wr_data_ready || app_wdf_wren)) proto_err++;
      if (app_wdf_wren !== app_wdf_end) proto_err++;
      if (wr_done) wr_done_cyc.push_back(cyc);
      if (rd_done) rd_done_cyc.push_back(cyc);
      if (rd_data_valid) begin
        rd_obs_q.push_back(rd_data);
        rd_obs_cyc.push_back(cyc);
      end
    end
  end

  // write-stream source and app_rdy pattern, updated just after each active edge
  always @(posedge clk) begin
    #1;
    if (bp_mode) app_rdy = ~app_rdy;
    wr_data_valid = (src_q.size() > 0);
    wr_data = wr_data_valid ? src_q[0] : '0;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_obs(input int n, input int max_cyc);
    for (int i = 0; i < max_cyc && obs_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
    wr_done_cyc.delete();
    rd_done_cyc.delete();
    rd_obs_q.delete();
    rd_obs_cyc.delete();
  endtask

  task automatic push_write(input logic [AW-1:0] a, input int len);
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      src_q.push_back(d);
      exp_q.push_back({3'b000, AW'(a + AW'(i * 8)), d, 2'b11});
    end
  endtask

  task automatic push_read(input logic [AW-1:0] a, input int len);
    for (int i = 0; i < len; i++)
      exp_q.push_back({3'b001, AW'(a + AW'(i * 8)), {DW{1'b0}}, 2'b00});
  endtask

  // tests
  task automatic test_reset();
    resetn = 1'b0;
    tick(3);
    checks++; if (app_en !== 1'b0) begin failures++; $display("FAIL reset_app_en: got %b want 0", app_en); end
    checks++; if (app_wdf_wren !== 1'b0) begin failures++; $display("FAIL reset_wren: got %b want 0", app_wdf_wren); end
    checks++; if (wr_data_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready: got %b want 0", wr_data_ready); end
    checks++; if ({wr_done, rd_done, rd_data_valid} !== 3'b000) begin failures++; $display("FAIL reset_pulses: got %b want 000", {wr_done, rd_done, rd_data_valid}); end
    checks++; if (app_addr !== '0 || app_cmd !== 3'b000) begin failures++; $display("FAIL reset_addr_cmd: got %h/%b want 0/000", app_addr, app_cmd); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    checks++; if ({app_wdf_mask, app_ref_req, app_zq_req} !== '0) begin failures++; $display("FAIL reset_ties: got %h want 0", {app_wdf_mask, app_ref_req, app_zq_req}); end
    resetn = 1'b1;
    tick(2);
  endtask

  task automatic test_calib_gating();
    int unsigned k;
    int unsigned last;
    logic [CW-1:0] e, o;
    int n;
    clear_obs();
    push_write(29'h40, 4);
    wr_addr = 29'h40; wr_len = 8'd4; wr_req = 1'b1;
    tick(50);
    checks++; if (obs_q.size() != 0 || wr_done_cyc.size() != 0) begin failures++; $display("FAIL calib_hold: got %0d cmds want 0", obs_q.size()); end
    init_calib_complete = 1'b1;
    k = cyc;
    wait_obs(1, 20);
    wr_req = 1'b0;
    wait_obs(4, 40);
    tick(3);
    checks++; if (obs_cyc.size() == 0 || obs_cyc[0] !== k + 1) begin failures++; $display("FAIL calib_latency: got cycle %0d want %0d", (obs_cyc.size() > 0) ? obs_cyc[0] : 0, k + 1); end
    last = (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size() - 1] : 0;
    checks++; if (wr_done_cyc.size() != 1 || wr_done_cyc[0] !== last + 1) begin failures++; $display("FAIL calib_done: got %0d pulses want 1 at %0d", wr_done_cyc.size(), last + 1); end
    n = exp_q.size();
    checks++; if (obs_q.size() != n) begin failures++; $display("FAIL calib_count: got %0d want %0d", obs_q.size(), n); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL calib_cmd: got %h want %h", o, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_single_write();
    logic [CW-1:0] e, o;
    int n;
    clear_obs();
    push_write(29'h100, 4);
    wr_addr = 29'h100; wr_len = 8'd4; wr_req = 1'b1;
    tick(1);
    wr_req = 1'b0;
    wait_obs(4, 40);
    tick(3);
    for (int i = 1; i < 4; i++) begin
      checks++; if (obs_cyc.size() != 4 || obs_cyc[i] !== obs_cyc[0] + i) begin failures++; $display("FAIL single_consecutive: beat %0d at %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i); end
    end
    checks++; if (wr_done_cyc.size() != 1 || wr_done_cyc[0] !== obs_cyc[0] + 4) begin failures++; $display("FAIL single_done: got %0d pulses want 1 at %0d", wr_done_cyc.size(), obs_cyc[0] + 4); end
    n = exp_q.size();
    checks++; if (obs_q.size() != n) begin failures++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), n); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL single_cmd: got %h want %h", o, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] e, o;
    int n;
    clear_obs();
    proto_err = 0;
    push_write(29'h100, 4);
    wr_addr = 29'h100; wr_len = 8'd4; wr_req = 1'b1;
    bp_mode = 1'b1;
    tick(1);
    wr_req = 1'b0;
    wait_obs(4, 60);
    tick(3);
    bp_mode = 1'b0;
    app_rdy = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checks++; if (obs_cyc.size() != 4 || obs_cyc[i] !== obs_cyc[i - 1] + 2) begin failures++; $display("FAIL bp_spacing: beat %0d at %0d want %0d", i, obs_cyc[i], obs_cyc[i - 1] + 2); end
    end
    checks++; if (proto_err != 0) begin failures++; $display("FAIL bp_ready_follows_rdy: got %0d violations want 0", proto_err); end
    checks++; if (wr_done_cyc.size() != 1) begin failures++; $display("FAIL bp_done: got %0d pulses want 1", wr_done_cyc.size()); end
    n = exp_q.size();
    checks++; if (obs_q.size() != n) begin failures++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), n); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL bp_cmd: got %h want %h", o, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_read_wrap();
    logic [CW-1:0] e, o;
    logic [DW-1:0] d0, d1, ed;
    int unsigned k;
    int n;
    clear_obs();
    push_read(29'h1FFFFFF8, 2);
    rd_addr = 29'h1FFFFFF8; rd_len = 8'd2; rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
    wait_obs(2, 30);
    tick(2);
    checks++; if (rd_done_cyc.size() != 1 || obs_cyc.size() != 2 || rd_done_cyc[0] !== obs_cyc[1] + 1) begin failures++; $display("FAIL read_done: got %0d pulses want 1", rd_done_cyc.size()); end
    n = exp_q.size();
    checks++; if (obs_q.size() != n) begin failures++; $display("FAIL read_count: got %0d want %0d", obs_q.size(), n); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL read_cmd: got %h want %h", o, e); end
    end
    exp_q.delete();
    d0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    d1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_rd_q.push_back(d0);
    exp_rd_q.push_back(d1);
    app_rd_data = d0; app_rd_data_valid = 1'b1;
    k = cyc;
    tick(1);
    app_rd_data = d1;
    tick(1);
    app_rd_data = '0; app_rd_data_valid = 1'b0;
    tick(3);
    checks++; if (rd_obs_q.size() != 2) begin failures++; $display("FAIL read_return_count: got %0d want 2", rd_obs_q.size()); end
    for (int i = 0; i < 2 && rd_obs_q.size() > 0; i++) begin
      ed = exp_rd_q.pop_front();
      checks++; if (rd_obs_q[0] !== ed || rd_obs_cyc[0] !== k + 1 + i) begin failures++; $display("FAIL read_return: got %h at %0d want %h at %0d", rd_obs_q[0], rd_obs_cyc[0], ed, k + 1 + i); end
      void'(rd_obs_q.pop_front());
      void'(rd_obs_cyc.pop_front());
    end
    exp_rd_q.delete();
  endtask

  task automatic test_round_robin();
    logic [CW-1:0] e, o;
    int n;
    clear_obs();
    push_write(29'h200, 2);
    push_read(29'h800, 2);
    push_write(29'h200, 2);
    push_read(29'h800, 2);
    wr_addr = 29'h200; wr_len = 8'd2;
    rd_addr = 29'h800; rd_len = 8'd2;
    wr_req = 1'b1; rd_req = 1'b1;
    wait_obs(8, 80);
    wr_req = 1'b0; rd_req = 1'b0;
    tick(4);
    for (int b = 0; b < 4; b++) begin
      checks++; if (obs_cyc.size() != 8 || obs_cyc[2 * b + 1] !== obs_cyc[2 * b] + 1) begin failures++; $display("FAIL rr_within_burst: burst %0d beats at %0d,%0d", b, obs_cyc[2 * b], obs_cyc[2 * b + 1]); end
      if (b > 0) begin
        checks++; if (obs_cyc[2 * b] !== obs_cyc[2 * b - 1] + 2) begin failures++; $display("FAIL rr_idle_gap: burst %0d at %0d want %0d", b, obs_cyc[2 * b], obs_cyc[2 * b - 1] + 2); end
      end
    end
    checks++; if (wr_done_cyc.size() != 2 || rd_done_cyc.size() != 2) begin failures++; $display("FAIL rr_done: got %0d/%0d want 2/2", wr_done_cyc.size(), rd_done_cyc.size()); end
    n = exp_q.size();
    checks++; if (obs_q.size() != n) begin failures++; $display("FAIL rr_count: got %0d want %0d", obs_q.size(), n); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL rr_cmd: got %h want %h", o, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_len_zero();
    logic [CW-1:0] e, o;
    int unsigned k;
    int n;
    clear_obs();
    wr_addr = 29'h500; wr_len = 8'd0; wr_req = 1'b1;
    k = cyc;
    tick(1);
    wr_req = 1'b0;
    tick(3);
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL len0_no_cmd: got %0d cmds want 0", obs_q.size()); end
    checks++; if (wr_done_cyc.size() != 1 || wr_done_cyc[0] !== k + 1) begin failures++; $display("FAIL len0_done: got %0d pulses at %0d want 1 at %0d", wr_done_cyc.size(), (wr_done_cyc.size() > 0) ? wr_done_cyc[0] : 0, k + 1); end
    // the empty write counts as the last grant, so the tie goes to the read
    clear_obs();
    push_read(29'h900, 1);
    push_write(29'h600, 1);
    rd_addr = 29'h900; rd_len = 8'd1;
    wr_addr = 29'h600; wr_len = 8'd1;
    wr_req = 1'b1; rd_req = 1'b1;
    wait_obs(2, 40);
    wr_req = 1'b0; rd_req = 1'b0;
    tick(3);
    n = exp_q.size();
    checks++; if (obs_q.size() != n) begin failures++; $display("FAIL len0_rr_count: got %0d want %0d", obs_q.size(), n); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL len0_rr_cmd: got %h want %h", o, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    logic [CW-1:0] e, o;
    int n;
    clear_obs();
    push_write(29'h300, 8);
    wr_addr = 29'h300; wr_len = 8'd8; wr_req = 1'b1;
    tick(1);
    wr_req = 1'b0;
    wait_obs(3, 40);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checks++; if ({app_en, app_wdf_wren, wr_data_ready, wr_done} !== 4'b0000) begin failures++; $display("FAIL midreset_outputs: got %b want 0000", {app_en, app_wdf_wren, wr_data_ready, wr_done}); end
    checks++; if (app_addr !== '0) begin failures++; $display("FAIL midreset_addr: got %h want 0", app_addr); end
    tick(2);
    src_q.delete();
    exp_q.delete();
    clear_obs();
    push_write(29'h700, 1);
    push_read(29'hA00, 1);
    wr_addr = 29'h700; wr_len = 8'd1;
    rd_addr = 29'hA00; rd_len = 8'd1;
    wr_req = 1'b1; rd_req = 1'b1;
    resetn = 1'b1;
    wait_obs(2, 40);
    wr_req = 1'b0; rd_req = 1'b0;
    tick(3);
    checks++; if (wr_done_cyc.size() != 1 || obs_cyc.size() == 0 || wr_done_cyc[0] !== obs_cyc[0] + 1) begin failures++; $display("FAIL midreset_done: got %0d write pulses want 1 after new burst", wr_done_cyc.size()); end
    n = exp_q.size();
    checks++; if (obs_q.size() != n) begin failures++; $display("FAIL midreset_count: got %0d want %0d", obs_q.size(), n); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL midreset_cmd: got %h want %h", o, e); end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_calib_gating();
    test_single_write();
    test_backpressure();
    test_read_wrap();
    test_round_robin();
    test_len_zero();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
